// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake from the host link plus the
// command write port toward the MC14500B Wrapper.
interface program_loader_if #(
    parameter int unsigned CMD_WIDTH = 12
) ();
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 program_write;
    logic [CMD_WIDTH-1:0] program_cmd;

    // Host/bench side: drives the stream, observes ready and the write port.
    modport master (
        output in_data, in_valid,
        input  in_ready, program_write, program_cmd
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, program_write, program_cmd
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: boot-time controller that assembles a length-prefixed byte
// stream into program commands for the MC14500B Wrapper, holding the core in
// reset until the last command is written.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR byte, error output).
module program_loader #(
    parameter int unsigned CMD_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus,
    input  logic              reload,
    output logic              core_reset,
    output logic              done,
    output logic              error
);
    localparam int unsigned CMD_BYTES = (CMD_WIDTH + 7) / 8;
    localparam int unsigned BYTE_W    = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int unsigned LOW_W     = (CMD_BYTES > 1) ? (CMD_BYTES - 1) * 8 : 8;
    localparam int unsigned MAX_L     = (ADDR_WIDTH >= 8) ? 255 : (1 << ADDR_WIDTH) - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic                 boot_q;
    logic [7:0]           len_q;
    logic [7:0]           word_cnt_q;
    logic [BYTE_W-1:0]    byte_cnt_q;
    logic [LOW_W-1:0]     buf_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 in_ready_q, write_q, core_reset_q, done_q;
    logic                 in_ready_d, write_d, core_reset_d, done_d;
    logic                 accept, last_byte, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_q;
    logic                 error_q, error_d;
`endif

    assign accept    = bus.in_valid & in_ready_q;
    assign last_byte = (byte_cnt_q == BYTE_W'(CMD_BYTES - 1));
    assign last_word = (word_cnt_q == len_q);

    assign bus.in_ready      = in_ready_q;
    assign bus.program_write = write_q;
    assign bus.program_cmd   = cmd_q;
    assign core_reset        = core_reset_q;
    assign done              = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign error             = error_q;
`else
    assign error             = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            // boot_q keeps IDLE for one full cycle after reset release.
            S_IDLE:  if (boot_q) state_d = S_LEN;
            S_LEN:   if (accept) state_d = S_DATA;
            S_DATA:  if (accept && last_byte) state_d = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:  if (accept) state_d = (bus.in_data == csum_q) ? S_RUN : S_ERROR;
            S_ERROR: if (reload) state_d = S_IDLE;
`endif
            S_RUN:   if (reload) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs align with it.
    always_comb begin
        in_ready_d   = 1'b0;
        write_d      = 1'b0;
        core_reset_d = 1'b1;
        done_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        error_d      = 1'b0;
`endif
        case (state_d)
            S_LEN, S_DATA, S_CSUM: in_ready_d = 1'b1;
            S_WRITE:               write_d    = 1'b1;
            S_RUN: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_ERROR:               error_d    = 1'b1;
`endif
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            write_q      <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            error_q      <= 1'b0;
`endif
        end else begin
            in_ready_q   <= in_ready_d;
            write_q      <= write_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
            error_q      <= error_d;
`endif
        end
    end

    // Length, counters and command assembly (low byte first).
    always_ff @(posedge clk) begin
        if (reset) begin
            boot_q     <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            cmd_q      <= '0;
        end else begin
            boot_q <= 1'b1;
            case (state_q)
                S_LEN: begin
                    word_cnt_q <= '0;
                    byte_cnt_q <= '0;
                    if (accept) begin
                        len_q <= (bus.in_data > 8'(MAX_L)) ? 8'(MAX_L) : bus.in_data;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            if (CMD_BYTES == 1) begin
                                cmd_q <= CMD_WIDTH'(bus.in_data);
                            end else begin
                                cmd_q <= CMD_WIDTH'({bus.in_data, buf_q});
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                            buf_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                        end
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_cnt_q <= word_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over the length byte and every command byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == S_IDLE) begin
            csum_q <= '0;
        end else if (accept && (state_q == S_LEN || state_q == S_DATA)) begin
            csum_q <= csum_q ^ bus.in_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Expected commands
// are queued as stimulus is driven; written commands are queued by a monitor
// and the two queues are compared in each scenario.
`timescale 1ns/1ps
module tb_program_loader;
    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic core_reset, done, error;

    always #5 clk = ~clk;

    program_loader_if #(.CMD_WIDTH(12)) bus ();

    program_loader #(.CMD_WIDTH(12), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .reload     (reload),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    int vectors    = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int accepts       = 0;
    int ready_in_write = 0;
    int long_pulse    = 0;
    logic prev_write  = 1'b0;

    // Monitor: record every write strobe and handshake anomalies.
    always @(negedge clk) begin
        if (!reset && bus.program_write) begin
            obs_q.push_back(bus.program_cmd);
            if (bus.in_ready) ready_in_write <= ready_in_write + 1;
            if (prev_write) long_pulse <= long_pulse + 1;
        end
        prev_write <= bus.program_write & ~reset;
    end

    // Count bytes actually transferred.
    always @(posedge clk) begin
        if (!reset && bus.in_valid && bus.in_ready) accepts <= accepts + 1;
    end

    // Present one byte until accepted; optional idle cycle afterwards.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte timeout byte=%h in_ready=%b exp 1", b, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Full stream with random commands and random ignored top-nibble bits.
    task automatic load_program(input int nwords, input bit gap, input bit corrupt);
        logic [7:0]  cs;
        logic [11:0] c;
        logic [7:0]  hi;
        cs = 8'(nwords - 1);
        send_byte(cs, gap);
        for (int w = 0; w < nwords; w++) begin
            c  = 12'($urandom);
            hi = {4'($urandom_range(15)), c[11:8]};
            send_byte(c[7:0], gap);
            exp_q.push_back(c);
            send_byte(hi, gap);
            cs = cs ^ c[7:0] ^ hi;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(corrupt ? ~cs : cs, gap);
`else
        if (corrupt) cs = ~cs;
`endif
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (done || error) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reload = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.in_ready, bus.program_write, core_reset, done, error, bus.program_cmd} !== {5'b00100, 12'h000}) begin
                miscompares++;
                $display("FAIL reset_hold[%0d] got rdy/wr/crst/done/err=%b cmd=%h exp 00100 000", i,
                         {bus.in_ready, bus.program_write, core_reset, done, error}, bus.program_cmd);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, core_reset} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_rel+1 got rdy/crst=%b exp 01", {bus.in_ready, core_reset});
        end
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, core_reset} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_rel+2 got rdy/crst=%b exp 11", {bus.in_ready, core_reset});
        end
    endtask

    task automatic test_single_word();
        logic [11:0] o;
        send_byte(8'h00, 1'b0);
        send_byte(8'h2A, 1'b0);
        exp_q.push_back(12'h12A);
        send_byte(8'h01, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h2B, 1'b0);
`else
        vectors++;
        if ({bus.in_ready, bus.program_write, core_reset, done, error} !== 5'b01100) begin
            miscompares++;
            $display("FAIL single_write_cycle got %b exp 01100",
                     {bus.in_ready, bus.program_write, core_reset, done, error});
        end
        @(negedge clk);
`endif
        vectors++;
        if ({bus.in_ready, bus.program_write, core_reset, done, error} !== 5'b00010) begin
            miscompares++;
            $display("FAIL single_run got %b exp 00010",
                     {bus.in_ready, bus.program_write, core_reset, done, error});
        end
        vectors++;
        if (obs_q.size() !== 1) begin
            miscompares++;
            $display("FAIL single_count got %0d exp 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            vectors++;
            if (o !== exp_q.pop_front()) begin
                miscompares++;
                $display("FAIL single_cmd got %h exp 12a", o);
            end
        end
        exp_q.delete(); obs_q.delete();
        pulse_reload();
        vectors++;
        if ({bus.in_ready, bus.program_write, core_reset, done, error} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reload_idle got %b exp 00100",
                     {bus.in_ready, bus.program_write, core_reset, done, error});
        end
    endtask

    task automatic test_backpressure();
        int a0, n;
        bit ok;
        logic [11:0] e, o;
        a0 = accepts;
        load_program(4, 1'b1, 1'b0);
        wait_done(ok);
        vectors++;
        if (!ok || done !== 1'b1 || core_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_done got done=%b crst=%b exp 1 0", done, core_reset);
        end
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL bp_cmd[%0d] got %h exp %h", n, o, e);
            end
            n++;
        end
        vectors++;
        if (n !== 4 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL bp_pulses got %0d(+%0d) exp 4", n, obs_q.size());
        end
`ifdef LOADER_CHECKSUM_EN
        n = 10;
`else
        n = 9;
`endif
        vectors++;
        if (accepts - a0 !== n) begin
            miscompares++;
            $display("FAIL bp_accepts got %0d exp %0d", accepts - a0, n);
        end
        vectors++;
        if (ready_in_write !== 0 || long_pulse !== 0) begin
            miscompares++;
            $display("FAIL bp_strobe got rdy_in_wr=%0d long=%0d exp 0 0", ready_in_write, long_pulse);
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_csum_error();
        bit ok;
        logic [11:0] o;
        pulse_reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h2A, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.program_write, core_reset, done, error} !== 5'b00101) begin
            miscompares++;
            $display("FAIL csum_err got %b exp 00101",
                     {bus.in_ready, bus.program_write, core_reset, done, error});
        end
        vectors++;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
        if (o !== 12'h12A) begin
            miscompares++;
            $display("FAIL csum_err_cmd got %h exp 12a", o);
        end
        exp_q.delete(); obs_q.delete();
        pulse_reload();
        vectors++;
        if ({core_reset, done, error} !== 3'b100) begin
            miscompares++;
            $display("FAIL csum_reload got %b exp 100", {core_reset, done, error});
        end
        load_program(3, 1'b0, 1'b0);
        wait_done(ok);
        vectors++;
        if (!ok || {done, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL csum_retry got done/err=%b exp 10", {done, error});
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    task automatic test_reset_mid_load();
        bit ok;
        int n;
        logic [11:0] e, o;
        logic [7:0] c;
        pulse_reload();
        send_byte(8'h07, 1'b0);
        for (int w = 0; w < 3; w++) begin
            c = 8'(w * 8'h11 + 8'h05);
            send_byte(c, 1'b0);
            exp_q.push_back({4'(w), c});
            send_byte(8'(w), 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.program_write, core_reset, done, error, bus.program_cmd} !== {5'b00100, 12'h000}) begin
            miscompares++;
            $display("FAIL midrst_outputs got %b cmd=%h exp 00100 000",
                     {bus.in_ready, bus.program_write, core_reset, done, error}, bus.program_cmd);
        end
        reset = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL midrst_cmd[%0d] got %h exp %h", n, o, e);
            end
            n++;
        end
        exp_q.delete(); obs_q.delete();
        load_program(8, 1'b0, 1'b0);
        wait_done(ok);
        vectors++;
        if (!ok || done !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_reload got done=%b exp 1", done);
        end
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL midrst_full_cmd[%0d] got %h exp %h", n, o, e);
            end
            n++;
        end
        vectors++;
        if (n !== 8 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL midrst_full_pulses got %0d(+%0d) exp 8", n, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_max_length();
        bit ok;
        int n, bad;
        logic [11:0] e, o;
        pulse_reload();
        load_program(256, 1'b0, 1'b0);
        wait_done(ok);
        vectors++;
        if (!ok || {done, core_reset, error} !== 3'b100) begin
            miscompares++;
            $display("FAIL maxlen_done got done/crst/err=%b exp 100", {done, core_reset, error});
        end
        n = 0; bad = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                if (bad < 5) $display("FAIL maxlen_cmd[%0d] got %h exp %h", n, o, e);
                bad++;
            end
            n++;
        end
        vectors++;
        if (n !== 256 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL maxlen_pulses got %0d(+%0d) exp 256", n, obs_q.size());
        end
        vectors++;
        if (ready_in_write !== 0 || long_pulse !== 0) begin
            miscompares++;
            $display("FAIL maxlen_strobe got rdy_in_wr=%0d long=%0d exp 0 0", ready_in_write, long_pulse);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
`ifdef LOADER_CHECKSUM_EN
        test_csum_error();
`endif
        test_reset_mid_load();
        test_max_length();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired, run did not complete");
        $fatal(1);
    end
endmodule
